// File: rtl/multiplier_8bit_seq_if.sv
// rtl/multiplier_8bit_seq_if.sv - start/busy/done handshake and operand/result bundle for the sequential multiplier
interface multiplier_8bit_seq_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/multiplier_8bit_seq.sv
// rtl/multiplier_8bit_seq.sv - 8x8 unsigned shift-and-add multiplier, one adder pass per cycle, 9 cycles start to done
module ripple_carry_adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o,
    output logic       cin_msb_o
);
    logic [8:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o    = carry[8];
    assign cin_msb_o = carry[7];
endmodule

module multiplier_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    multiplier_8bit_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry_out;
    logic                 rca_cin_msb_unused;
    logic [2*WIDTH-1:0]   acc_shifted;

    // Only the multiplicand or zero is added, selected by the multiplier bit about to be shifted out.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    ripple_carry_adder_8bit u_rca (
        .a_i       (acc_hi_q),
        .b_i       (addend),
        .cin_i     (1'b0),
        .sum_o     (sum),
        .cout_o    (carry_out),
        .cin_msb_o (rca_cin_msb_unused)
    );

    assign acc_shifted = {carry_out, sum, acc_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    mcand_d  = bus.a;
                    acc_hi_d = '0;
                    acc_lo_d = bus.b;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_hi_d = acc_shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = acc_shifted[WIDTH-1:0];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d   = DONE;
                    product_d = acc_shifted;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_multiplier_8bit_seq.sv
// tb/tb_multiplier_8bit_seq.sv - scoreboard bench for the sequential multiplier
module tb_multiplier_8bit_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q[$];

    multiplier_8bit_seq_if bus ();

    multiplier_8bit_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [7:0] av, input logic [7:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        exp_q.push_back(16'(av) * 16'(bv));
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
    endtask

    // Called in cycle start_lat after the accepting edge; returns in the done cycle.
    task automatic wait_done(input string tag, input int start_lat, output int busy_cnt);
        int lat;
        lat      = start_lat;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        check(tag, lat, 9);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_mutex", {31'b0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0)
                    check("spurious_done", {31'b0, bus.done}, 32'd0);
                else
                    check("product", {16'b0, bus.product}, {16'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        // reset and idle hold
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_product", {16'b0, bus.product}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            tick();
            if (i % 5 == 4) begin
                check("idle_busy", {31'b0, bus.busy}, 32'd0);
                check("idle_product", {16'b0, bus.product}, 32'h0);
            end
        end

        // basic operation and latency
        drive_start(8'd13, 8'd11);
        wait_done("lat_13x11", 1, bc);
        check("busy_cycles", bc, 8);
        check("product_13x11", {16'b0, bus.product}, 32'h008F);
        tick();
        check("done_pulse", {31'b0, bus.done}, 32'd0);

        // corner operands
        drive_start(8'd255, 8'd255);
        wait_done("lat_ff", 1, bc);
        check("product_max", {16'b0, bus.product}, 32'hFE01);
        tick();
        drive_start(8'd0, 8'd200);
        wait_done("lat_zero", 1, bc);
        tick();
        drive_start(8'd200, 8'd1);
        wait_done("lat_one", 1, bc);
        check("product_200x1", {16'b0, bus.product}, 32'h00C8);
        tick();

        // start while busy is ignored
        drive_start(8'd7, 8'd6);
        tick();
        tick();
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("lat_ignored", 4, bc);
        check("product_7x6", {16'b0, bus.product}, 32'h002A);
        tick();
        tick();
        check("no_restart", {31'b0, bus.busy}, 32'd0);

        // reset mid-operation abandons it
        drive_start(8'd5, 8'd5);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_product", {16'b0, bus.product}, 32'h0);
        for (int i = 0; i < 15; i++) begin
            check("abort_no_done", {31'b0, bus.done}, 32'd0);
            tick();
        end

        // back-to-back with product hold
        drive_start(8'd3, 8'd4);
        wait_done("lat_3x4", 1, bc);
        check("product_3x4", {16'b0, bus.product}, 32'h000C);
        drive_start(8'd16, 8'd16);
        begin
            int lat;
            lat = 1;
            while (!bus.done && lat < 40) begin
                check("product_hold", {16'b0, bus.product}, 32'h000C);
                tick();
                lat++;
            end
            check("lat_b2b", lat, 9);
        end
        check("product_16x16", {16'b0, bus.product}, 32'h0100);

        // random back-to-back sweep
        drive_start(8'($urandom), 8'($urandom));
        for (int i = 1; i < 1000; i++) begin
            wait_done("sweep_spacing", 1, bc);
            drive_start(8'($urandom), 8'($urandom));
        end
        wait_done("sweep_spacing", 1, bc);
        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
